// File: rtl/byte_lane_ram_pkg.sv
// rtl/byte_lane_ram_pkg.sv - shared state encoding and lane geometry helpers
//
// Purpose: common definitions for byte_lane_ram and its lane memories.
//   state_t        : controller state (CLEAR = zero-fill running, READY = serving)
//   lane_num(dw)   : number of byte lanes for a data width
//   lane_bits(dw)  : log2 of the lane count, i.e. byte-offset bits in an address
package byte_lane_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int lane_num(input int dw);
    return dw / 8;
  endfunction

  function automatic int lane_bits(input int dw);
    int n;
    int b;
    n = dw / 8;
    b = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) b = i + 1;
    end
    return b;
  endfunction

endpackage

// File: rtl/byte_lane_mem.sv
// rtl/byte_lane_mem.sv - one 8-bit wide, MEM_NUM deep, 1W1R synchronous lane
//
// Purpose: storage for a single byte lane; plain RAM with no reset so it maps
//          onto block memory.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write word index
//   wdata : write byte
//   re    : read enable; rdata loads only when set and holds otherwise
//   raddr : read word index
//   rdata : registered read byte (old contents on a same-address write)
module byte_lane_mem #(
  parameter int MEM_NUM = 4096,
  parameter int IW      = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MEM_NUM];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/byte_lane_ram.sv
// rtl/byte_lane_ram.sv - byte-lane writable RAM with zero-fill and write-first reads
//
// Purpose: DW-wide RAM built from DW/8 byte lanes, byte addressed, with an
//          optional zero-fill sweep after reset and per-lane write-first
//          forwarding on same-word read/write.
// Ports:
//   clk     : clock, rising edge
//   rstn    : synchronous active-low reset
//   wen     : per-lane write enable
//   w_addr  : write byte address
//   w_data  : write data, lane i = bits [8i+7:8i]
//   ren     : read request
//   r_addr  : read byte address
//   r_data  : read data, holds until the next completed read
//   r_valid : one-cycle pulse when a read completes
//   r_err   : with r_valid, read index was out of range (r_data = 0)
//   busy    : zero-fill in progress, requests ignored
module byte_lane_ram
  import byte_lane_ram_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_NUM    = 4096,
  parameter int CLR_ON_RST = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [lane_num(DW)-1:0] wen,
  input  logic [AW-1:0]          w_addr,
  input  logic [DW-1:0]          w_data,
  input  logic                   ren,
  input  logic [AW-1:0]          r_addr,
  output logic [DW-1:0]          r_data,
  output logic                   r_valid,
  output logic                   r_err,
  output logic                   busy
);

  localparam int NL = lane_num(DW);
  localparam int LB = lane_bits(DW);
  localparam int WW = AW - LB;
  localparam int IW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
  // One spare bit so MEM_NUM-1 compares cleanly even for power-of-two depths.
  localparam int CW = $clog2(MEM_NUM) + 1;

  state_t         state;
  logic [CW-1:0]  cnt;

  logic [WW-1:0]  w_idx;
  logic [WW-1:0]  r_idx;
  logic           w_ok;
  logic           r_ok;
  logic           clearing;
  logic           rd_acc;

  // Read-side selects, captured with the read so r_data holds between reads.
  logic           rd_zero;
  logic [NL-1:0]  rd_fwd;
  logic [DW-1:0]  fwd_data;
  logic [7:0]     lane_q [NL];

  assign w_idx    = w_addr[AW-1:LB];
  assign r_idx    = r_addr[AW-1:LB];
  assign w_ok     = 64'(w_idx) < 64'(MEM_NUM);
  assign r_ok     = 64'(r_idx) < 64'(MEM_NUM);
  assign clearing = (state == CLEAR);
  assign rd_acc   = rstn && (state == READY) && ren;
  assign busy     = clearing;

  if (LB > 0) begin : g_low_bits
    logic unused_low;
    assign unused_low = ^{w_addr[LB-1:0], r_addr[LB-1:0]};
  end

  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic          we;
    logic [IW-1:0] wa;
    logic [7:0]    wd;

    assign we = rstn && (clearing || ((state == READY) && wen[i] && w_ok));
    assign wa = clearing ? cnt[IW-1:0] : w_idx[IW-1:0];
    assign wd = clearing ? 8'h00 : w_data[8*i +: 8];

    byte_lane_mem #(
      .MEM_NUM (MEM_NUM),
      .IW      (IW)
    ) u_lane (
      .clk   (clk),
      .we    (we),
      .waddr (wa),
      .wdata (wd),
      .re    (rd_acc && r_ok),
      .raddr (r_idx[IW-1:0]),
      .rdata (lane_q[i])
    );

    // Lane RAM returns old data on a collision; the captured write byte wins.
    assign r_data[8*i +: 8] = rd_zero   ? 8'h00 :
                              rd_fwd[i] ? fwd_data[8*i +: 8] : lane_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= (CLR_ON_RST != 0) ? CLEAR : READY;
      cnt      <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      rd_zero  <= 1'b1;
      rd_fwd   <= '0;
      fwd_data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(MEM_NUM - 1)) state <= READY;
        end
        default: state <= READY;
      endcase

      r_valid <= rd_acc;
      r_err   <= rd_acc && !r_ok;

      if (rd_acc) begin
        rd_zero  <= !r_ok;
        fwd_data <= w_data;
        for (int i = 0; i < NL; i++) begin
          rd_fwd[i] <= wen[i] && w_ok && (w_idx == r_idx);
        end
      end
    end
  end

endmodule
